// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: decomposes the shift amount into power-of-two stages and
// applies one set stage per clock; result returned over a valid/ready handshake.
module shift_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic [SHAMT_W-1:0] top_bit;
    logic [WIDTH-1:0]   fill_mask;
    logic [WIDTH-1:0]   stage_val;

    // Ready depends on the consumer in DONE so a new op can load with no bubble.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // The highest set bit of the remaining amount is also the stage's shift distance.
    always_comb begin
        top_bit = '0;
        for (int i = 0; i < int'(SHAMT_W); i++) begin
            if (rem_q[i]) begin
                top_bit = SHAMT_W'(1) << i;
            end
        end
    end

    always_comb begin
        fill_mask = ~({WIDTH{1'b1}} >> top_bit);
        if (!dir_q) begin
            stage_val = work_q << top_bit;
        end else if (arith_q && sign_q) begin
            stage_val = (work_q >> top_bit) | fill_mask;
        end else begin
            stage_val = work_q >> top_bit;
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        arith_d  = arith_q;
        sign_d   = sign_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d  = a;
                    rem_d   = shamt;
                    dir_d   = dir;
                    arith_d = arith;
                    sign_d  = a[WIDTH-1];
                    state_d = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                work_d = stage_val;
                rem_d  = rem_q & ~top_bit;
                if ((rem_q & ~top_bit) == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = a;
                        rem_d   = shamt;
                        dir_d   = dir;
                        arith_d = arith;
                        sign_d  = a[WIDTH-1];
                        state_d = (shamt != '0) ? SHIFT : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over both acceptance and completion.
        if (flush) begin
            state_d = IDLE;
        end

        result_d    = (state_d == DONE) ? work_d : result_q;
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            dir_q       <= 1'b0;
            arith_q     <= 1'b0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            dir_q       <= dir_d;
            arith_q     <= arith_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: accepted requests push an expected
// result and latency; a negedge monitor checks every presented result.
module tb_shift_sequencer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    logic               dir;
    logic               arith;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               busy;

    shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .shamt     (shamt),
        .dir       (dir),
        .arith     (arith),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               acc_cyc;
        int               lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    logic first_valid = 1'b1;
    logic prev_valid = 1'b0, prev_rdy = 1'b0, prev_flush = 1'b0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] av, input int sh,
                                               input logic d, input logic ar);
        if (!d)
            return av << sh;
        else if (ar)
            return WIDTH'($signed(av) >>> sh);
        else
            return av >> sh;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      out_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 1) out_ready = 1'b1;
        else                    out_ready = 1'b0;
    end

    // Monitor and scoreboard bookkeeping.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            first_valid = 1'b1;
            prev_valid = 1'b0; prev_rdy = 1'b0; prev_flush = 1'b0;
        end else begin
            if (prev_valid && !prev_rdy && !prev_flush)
                chk("valid_hold", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_valid: out_valid=1 result=0x%08h with nothing expected", result);
                end else begin
                    chk("result", result, q[0].res);
                    if (first_valid) begin
                        chk("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
                        first_valid = 1'b0;
                    end
                end
            end
            if (flush) begin
                q.delete();
                first_valid = 1'b1;
            end else begin
                if (out_valid && out_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    first_valid = 1'b1;
                end
                if (in_valid && in_ready)
                    q.push_back('{res: model(a, int'(shamt), dir, arith),
                                  acc_cyc: cyc, lat: 1 + $countones(shamt)});
            end
            prev_valid = out_valid; prev_rdy = out_ready; prev_flush = flush;
        end
    end

    // Called and returns at posedge+#1; holds the request until accepted.
    task automatic send(input logic [WIDTH-1:0] av, input logic [SHAMT_W-1:0] sh,
                        input logic d, input logic ar);
        logic acc;
        int   n;
        in_valid = 1'b1; a = av; shamt = sh; dir = d; arith = ar;
        acc = 1'b0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: request a=0x%08h never accepted", av);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n >= 300) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d results still pending", q.size());
        end
    endtask

    initial begin
        logic [WIDTH-1:0] r0;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; shamt = '0; dir = 1'b0;
        arith = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while shifting drops everything immediately.
        send(32'h8000_0000, 5'd31, 1'b1, 1'b1);
        chk("busy_mid_shift", 32'(busy), 32'd1);
        rst_n = 1'b0; #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk); @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'h0000_00FF, 5'd8, 1'b0, 1'b0);
        drain();
        send(32'h8000_0000, 5'd31, 1'b1, 1'b1);
        drain();
        send(32'h8000_0000, 5'd31, 1'b1, 1'b0);
        drain();

        // Zero shift held in DONE by a stalled consumer.
        rdy_mode = 2;
        send(32'h1234_5678, 5'd0, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        r0 = result;
        chk("hold_first_result", r0, 32'h1234_5678);
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result, r0);
        end
        @(posedge clk); #1; rdy_mode = 1;
        drain();

        // Second request loads in the same cycle the first result is taken.
        send(32'h0000_00FF, 5'd8, 1'b0, 1'b0);
        send(32'hF000_0000, 5'd4, 1'b1, 1'b1);
        drain();

        // Flush one cycle into a long op.
        send(32'h8000_0000, 5'd31, 1'b1, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        send(32'h0F0F_0F0F, 5'd5, 1'b0, 1'b0);
        drain();

        rdy_mode = 0;
        for (int i = 0; i < 200; i++) begin
            send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
                flush = 1'b1;
                @(posedge clk); #1; flush = 1'b0;
            end
        end
        rdy_mode = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
